ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage of the 16-bit pipelined CPU.
- Captures the EX-stage ALU result, including the saturating nibble-add (PADDSB) lane result, together with its control bits.
- Owns the architectural Z/V/N flag register.
- Implements stall, flush and halt-drain sequencing for the memory stage.
- Consumes the ALU output directly; feeds the MEM stage, the forwarding unit and the branch logic in ID.

Parameters:
- DW, 16, datapath width (ALU result, store data).
- RW, 4, register-specifier width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold stage contents and flags this cycle.
- flush_i  in  1  squash the incoming EX instruction (load a bubble).
- ex_valid  in  1  EX holds a real instruction.
- ex_opcode  in  4  EX opcode.
- ex_alu_result  in  DW  ALU output (already saturated for ADD/SUB/PADDSB).
- ex_alu_ovfl  in  1  ALU signed-overflow/saturation indicator for ADD/SUB.
- ex_rd  in  RW  destination register.
- ex_reg_write  in  1  write-back enable.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_store_data  in  DW  store data (post-forwarding).
- mem_valid  out  1  MEM holds a real instruction.
- mem_opcode  out  4  registered opcode.
- mem_alu_result  out  DW  registered ALU result / memory address.
- mem_rd  out  RW  registered destination register.
- mem_reg_write  out  1  registered write-back enable.
- mem_mem_read  out  1  registered load enable.
- mem_mem_write  out  1  registered store enable.
- mem_store_data  out  DW  registered store data.
- mem_halt  out  1  HLT is in MEM (one-cycle pulse).
- halted_o  out  1  sticky; core has halted.
- flag_z  out  1  zero flag.
- flag_v  out  1  overflow flag.
- flag_n  out  1  negative flag.

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0; FSM goes to RUN.
  - Reset mid-operation discards the in-flight instruction and clears flags and halt state.
- Capture condition, "cap" = FSM in RUN and !stall_i and !flush_i and ex_valid.
- Priority, evaluated per clock edge:
  1. Reset.
  2. stall_i: all registers, flags and FSM hold; a simultaneous flush_i is ignored. Upstream must re-assert flush after the stall releases.
  3. flush_i: load a bubble; flags are unchanged.
  4. Normal capture.
- Bubble: mem_valid and every control bit (mem_reg_write, mem_mem_read, mem_mem_write, mem_halt) are 0. Data fields are don't-care, driven 0.
- Normal capture with ex_valid = 0: a bubble is loaded.
- Latency: exactly 1 cycle from EX inputs to MEM outputs.
- Flag update, only on a cap cycle; evaluation uses ex_alu_result, not a registered value:
  - ADD 0000, SUB 0001: Z = (result == 0); V = ex_alu_ovfl; N = result[15].
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: Z updates; V and N hold.
  - All other opcodes, including PADDSB 0111, RED 0011, LW, SW, LLB, LHB, B, BR, PCS, HLT: all flags hold.
- Flag visibility: a new flag value is visible on flag_* the cycle after capture. ID branch logic must stall one cycle after a flag-setting instruction. Flag bypass is not in this block.
- FSM states, with transitions:
  - RUN: cap with opcode HLT 1111 captures normally with mem_halt = 1, then goes to DRAIN.
  - DRAIN: mem_halt is 1 for exactly this one cycle. The stage loads a bubble regardless of inputs. Next state is HALTED; halted_o is set on entry to HALTED.
  - HALTED: every cycle loads a bubble; flags are frozen; halted_o stays 1 until reset.
  - stall_i holds the FSM in any state; DRAIN is extended while stalled, and mem_halt stays 1.
- A flushed HLT does not halt.
- No arithmetic is performed beyond the 16-bit zero compare; no width extension occurs.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode localparams (OP_ADD … OP_HLT);
  - the flag_t packed struct {z, v, n};
  - the ex_mem_t packed struct bundling the registered fields;
  - the halt FSM enum {RUN, DRAIN, HALTED}.
- One sub-module, flag_reg:
  - inputs: clk, rst_n, update enable, opcode, result, ovfl;
  - owns the per-opcode Z/V/N write-enable decode and the three flops.
- The pipeline register and FSM stay in ex_mem_stage.

Test Plan:
- Reset then ADD: ex_alu_result = 0x0000, ovfl = 0, rd = 3, reg_write = 1. Next cycle: mem_valid = 1, mem_rd = 3, Z = 1, V = 0, N = 0.
- SUB saturated: result 0x8000, ovfl = 1 → Z = 0, V = 1, N = 1. Then XOR with result 0x0000 → Z = 1, V = 1 and N = 1 held. Then PADDSB with result 0x7777 → flags unchanged.
- stall_i held 3 cycles with new EX inputs (SW, store_data 0xBEEF): outputs and flags are frozen throughout. On release, mem_mem_write = 1 and mem_store_data = 0xBEEF one cycle later.
- flush_i with an ADD whose result is 0x0000: mem_valid = 0, all controls 0, Z unchanged. With stall_i and flush_i both high: stage holds its previous contents.
- HLT captured:
  - mem_halt = 1 for one cycle (DRAIN), then halted_o = 1.
  - A following ADD is never captured and flags never change.
  - Stalling during DRAIN keeps mem_halt = 1 until release.
- Assert rst_n low asynchronously mid-cycle while in HALTED with Z = 1. All outputs go to 0 immediately, without waiting for a clock edge. After release, an ADD with result 0x0005 captures normally: Z = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, flag/pipeline structs and halt FSM states
package cpu_pkg;

    localparam int CPU_DW = 16;
    localparam int CPU_RW = 4;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flag_t;

    typedef struct packed {
        logic              valid;
        logic [3:0]        opcode;
        logic [CPU_DW-1:0] alu_result;
        logic [CPU_RW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [CPU_DW-1:0] store_data;
        logic              halt;
    } ex_mem_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } halt_state_e;

endpackage

// File: rtl/flag_reg.sv
// rtl/flag_reg.sv - architectural Z/V/N flags with per-opcode write enables
module flag_reg
    import cpu_pkg::*;
#(
    parameter int DW = CPU_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          upd_en,
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] result,
    input  logic          ovfl,
    output flag_t         flags
);

    flag_t flags_q;
    flag_t flags_d;

    always_comb begin
        flags_d = flags_q;
        if (upd_en) begin
            case (opcode)
                OP_ADD, OP_SUB: begin
                    flags_d.z = (result == '0);
                    flags_d.v = ovfl;
                    flags_d.n = result[DW-1];
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                    flags_d.z = (result == '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register, flag owner and halt-drain FSM
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DW = CPU_DW,
    parameter int RW = CPU_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_alu_result,
    input  logic          ex_alu_ovfl,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_reg_write,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic [DW-1:0] ex_store_data,
    output logic          mem_valid,
    output logic [3:0]    mem_opcode,
    output logic [DW-1:0] mem_alu_result,
    output logic [RW-1:0] mem_rd,
    output logic          mem_reg_write,
    output logic          mem_mem_read,
    output logic          mem_mem_write,
    output logic [DW-1:0] mem_store_data,
    output logic          mem_halt,
    output logic          halted_o,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n
);

    halt_state_e state_q, state_d;
    ex_mem_t     ex_mem_q, ex_mem_d;
    flag_t       flags;
    logic        cap;

    assign cap = (state_q == RUN) && !stall_i && !flush_i && ex_valid;

    // Any non-stalled edge that is not a capture loads a bubble (all zero).
    always_comb begin
        state_d  = state_q;
        ex_mem_d = ex_mem_q;
        if (!stall_i) begin
            ex_mem_d = '0;
            if (cap) begin
                ex_mem_d.valid      = 1'b1;
                ex_mem_d.opcode     = ex_opcode;
                ex_mem_d.alu_result = ex_alu_result;
                ex_mem_d.rd         = ex_rd;
                ex_mem_d.reg_write  = ex_reg_write;
                ex_mem_d.mem_read   = ex_mem_read;
                ex_mem_d.mem_write  = ex_mem_write;
                ex_mem_d.store_data = ex_store_data;
                ex_mem_d.halt       = (ex_opcode == OP_HLT);
            end
            case (state_q)
                RUN:     if (cap && ex_opcode == OP_HLT) state_d = DRAIN;
                DRAIN:   state_d = HALTED;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            ex_mem_q <= '0;
        end else begin
            state_q  <= state_d;
            ex_mem_q <= ex_mem_d;
        end
    end

    flag_reg #(.DW(DW)) u_flag_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .upd_en (cap),
        .opcode (ex_opcode),
        .result (ex_alu_result),
        .ovfl   (ex_alu_ovfl),
        .flags  (flags)
    );

    assign mem_valid      = ex_mem_q.valid;
    assign mem_opcode     = ex_mem_q.opcode;
    assign mem_alu_result = ex_mem_q.alu_result;
    assign mem_rd         = ex_mem_q.rd;
    assign mem_reg_write  = ex_mem_q.reg_write;
    assign mem_mem_read   = ex_mem_q.mem_read;
    assign mem_mem_write  = ex_mem_q.mem_write;
    assign mem_store_data = ex_mem_q.store_data;
    assign mem_halt       = ex_mem_q.halt;
    assign halted_o       = (state_q == HALTED);
    assign flag_z         = flags.z;
    assign flag_v         = flags.v;
    assign flag_n         = flags.n;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_alu_result;
    logic        ex_alu_ovfl;
    logic [3:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [15:0] ex_store_data;
    logic        mem_valid;
    logic [3:0]  mem_opcode;
    logic [15:0] mem_alu_result;
    logic [3:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic [15:0] mem_store_data;
    logic        mem_halt;
    logic        halted_o;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    int checks;
    int errors;

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_alu_result  (ex_alu_result),
        .ex_alu_ovfl    (ex_alu_ovfl),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_store_data  (ex_store_data),
        .mem_valid      (mem_valid),
        .mem_opcode     (mem_opcode),
        .mem_alu_result (mem_alu_result),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_store_data (mem_store_data),
        .mem_halt       (mem_halt),
        .halted_o       (halted_o),
        .flag_z         (flag_z),
        .flag_v         (flag_v),
        .flag_n         (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [3:0] op, input logic [15:0] res, input logic ovfl,
                          input logic [3:0] rd, input logic rw, input logic mr,
                          input logic mw, input logic [15:0] sd);
        ex_valid      = 1'b1;
        ex_opcode     = op;
        ex_alu_result = res;
        ex_alu_ovfl   = ovfl;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_store_data = sd;
    endtask

    task automatic chk_flags(input string tag, input logic z, input logic v, input logic n);
        chk({tag, ".z"}, {31'd0, flag_z}, {31'd0, z});
        chk({tag, ".v"}, {31'd0, flag_v}, {31'd0, v});
        chk({tag, ".n"}, {31'd0, flag_n}, {31'd0, n});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, {31'd0, mem_valid}, 32'd0);
        chk({tag, ".opcode"}, {28'd0, mem_opcode}, 32'd0);
        chk({tag, ".result"}, {16'd0, mem_alu_result}, 32'd0);
        chk({tag, ".rd"}, {28'd0, mem_rd}, 32'd0);
        chk({tag, ".ctrl"}, {29'd0, mem_reg_write, mem_mem_read, mem_mem_write}, 32'd0);
        chk({tag, ".sdata"}, {16'd0, mem_store_data}, 32'd0);
        chk({tag, ".halt"}, {30'd0, mem_halt, halted_o}, 32'd0);
        chk_flags(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        ex_valid = 1'b0;
        ex_opcode = 4'h0;
        ex_alu_result = 16'h0;
        ex_alu_ovfl = 1'b0;
        ex_rd = 4'h0;
        ex_reg_write = 1'b0;
        ex_mem_read = 1'b0;
        ex_mem_write = 1'b0;
        ex_store_data = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ADD result 0 -> Z=1
        set_ex(4'h0, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        chk("add.valid", {31'd0, mem_valid}, 32'd1);
        chk("add.rd", {28'd0, mem_rd}, 32'd3);
        chk("add.rw", {31'd0, mem_reg_write}, 32'd1);
        chk_flags("add", 1'b1, 1'b0, 1'b0);

        // SUB saturated
        set_ex(4'h1, 16'h8000, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        chk("sub.result", {16'd0, mem_alu_result}, 32'h8000);
        chk_flags("sub", 1'b0, 1'b1, 1'b1);

        // XOR touches Z only
        set_ex(4'h2, 16'h0000, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        chk_flags("xor", 1'b1, 1'b1, 1'b1);

        // PADDSB leaves flags alone
        set_ex(4'h7, 16'h7777, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        chk("paddsb.result", {16'd0, mem_alu_result}, 32'h7777);
        chk("paddsb.opcode", {28'd0, mem_opcode}, 32'h7);
        chk_flags("paddsb", 1'b1, 1'b1, 1'b1);

        // Stall three cycles with a pending SW
        set_ex(4'h9, 16'h0010, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.opcode", {28'd0, mem_opcode}, 32'h7);
            chk("stall.result", {16'd0, mem_alu_result}, 32'h7777);
            chk("stall.mw", {31'd0, mem_mem_write}, 32'd0);
            chk_flags("stall", 1'b1, 1'b1, 1'b1);
        end
        stall_i = 1'b0;
        tick();
        chk("sw.mw", {31'd0, mem_mem_write}, 32'd1);
        chk("sw.sdata", {16'd0, mem_store_data}, 32'hBEEF);
        chk("sw.rw", {31'd0, mem_reg_write}, 32'd0);

        // ADD 0x0005 -> Z=0, V=0, N=0
        set_ex(4'h0, 16'h0005, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        chk_flags("add5", 1'b0, 1'b0, 1'b0);

        // Flush an ADD of 0: bubble, Z unchanged
        set_ex(4'h0, 16'h0000, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 16'h1234);
        flush_i = 1'b1;
        tick();
        chk("flush.valid", {31'd0, mem_valid}, 32'd0);
        chk("flush.ctrl", {28'd0, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt}, 32'd0);
        chk("flush.result", {16'd0, mem_alu_result}, 32'd0);
        chk_flags("flush", 1'b0, 1'b0, 1'b0);
        flush_i = 1'b0;

        // Capture, then stall+flush together holds contents
        set_ex(4'h0, 16'h0005, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        set_ex(4'h0, 16'h0000, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 16'h0);
        stall_i = 1'b1;
        flush_i = 1'b1;
        tick();
        chk("stflush.valid", {31'd0, mem_valid}, 32'd1);
        chk("stflush.rd", {28'd0, mem_rd}, 32'd7);
        chk_flags("stflush", 1'b0, 1'b0, 1'b0);
        stall_i = 1'b0;
        flush_i = 1'b0;

        // Flushed HLT does not halt
        set_ex(4'hF, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        ex_valid = 1'b0;
        tick();
        chk("flushhlt.halt", {30'd0, mem_halt, halted_o}, 32'd0);

        // ADD of 0 sets Z=1 before the halt sequence
        set_ex(4'h0, 16'h0000, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        chk_flags("preh", 1'b1, 1'b0, 1'b0);

        // HLT capture, DRAIN stretched by a stall
        set_ex(4'hF, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick();
        chk("hlt.halt", {31'd0, mem_halt}, 32'd1);
        chk("hlt.valid", {31'd0, mem_valid}, 32'd1);
        chk("hlt.halted", {31'd0, halted_o}, 32'd0);
        set_ex(4'h0, 16'h0005, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0);
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("drainstall.halt", {31'd0, mem_halt}, 32'd1);
            chk("drainstall.halted", {31'd0, halted_o}, 32'd0);
        end
        stall_i = 1'b0;
        tick();
        chk("halted.halt", {31'd0, mem_halt}, 32'd0);
        chk("halted.halted", {31'd0, halted_o}, 32'd1);
        chk("halted.valid", {31'd0, mem_valid}, 32'd0);
        tick();
        chk("halted2.valid", {31'd0, mem_valid}, 32'd0);
        chk("halted2.halted", {31'd0, halted_o}, 32'd1);
        chk_flags("halted2", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("areset");
        @(negedge clk);
        rst_n = 1'b1;
        set_ex(4'h0, 16'h0005, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        chk("post.valid", {31'd0, mem_valid}, 32'd1);
        chk("post.result", {16'd0, mem_alu_result}, 32'h0005);
        chk_flags("post", 1'b0, 1'b0, 1'b0);
        set_ex(4'h0, 16'h0000, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        chk_flags("post2", 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
